// File: rtl/activation_stage_pkg.sv
// Shared widths and occupancy states for the activation stage
// and its output buffer.
package activation_stage_pkg;

   localparam int unsigned MAC_W = 21;
   localparam int unsigned ACT_W = 8;
   localparam logic [ACT_W-1:0] ACT_MAX = 8'd255;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_e;

   function automatic int unsigned idx_w(int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/activation_stage_fifo.sv
// Two-entry first-in first-out buffer with an explicit occupancy FSM.
// Entries are discarded by reset or clr.
module act_fifo
   import activation_stage_pkg::*;
#(
   parameter int unsigned DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          push,
   input  logic          pop,
   input  logic [DW-1:0] wdata,
   output logic          not_full,
   output logic          not_empty,
   output logic [DW-1:0] rdata
);

   occ_e          state_q, state_d;
   logic          wr_q, wr_d;
   logic          rd_q, rd_d;
   logic [DW-1:0] mem_q [2];
   logic [DW-1:0] mem_d [2];
   logic          do_push;
   logic          do_pop;

   assign not_full  = (state_q != OCC_FULL);
   assign not_empty = (state_q != OCC_EMPTY);
   assign rdata     = mem_q[rd_q];
   assign do_push   = push && not_full;
   assign do_pop    = pop && not_empty;

   always_comb begin
      state_d = state_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      mem_d   = mem_q;
      if (clr) begin
         state_d = OCC_EMPTY;
         wr_d    = 1'b0;
         rd_d    = 1'b0;
      end else begin
         if (do_push) begin
            mem_d[wr_q] = wdata;
            wr_d        = ~wr_q;
         end
         if (do_pop) begin
            rd_d = ~rd_q;
         end
         unique case (state_q)
            OCC_EMPTY: if (do_push) state_d = OCC_ONE;
            OCC_ONE: begin
               if (do_push && !do_pop) state_d = OCC_FULL;
               if (do_pop && !do_push) state_d = OCC_EMPTY;
            end
            OCC_FULL: if (do_pop) state_d = OCC_ONE;
            default: state_d = OCC_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= OCC_EMPTY;
         wr_q     <= 1'b0;
         rd_q     <= 1'b0;
         mem_q[0] <= '0;
         mem_q[1] <= '0;
      end else begin
         state_q  <= state_d;
         wr_q     <= wr_d;
         rd_q     <= rd_d;
         mem_q[0] <= mem_d[0];
         mem_q[1] <= mem_d[1];
      end
   end

endmodule

// File: rtl/activation_stage.sv
// ReLU + rounded rescale + saturation of MAC results, tagged with a
// wrapping neuron index and buffered for the next layer.
module activation_stage
   import activation_stage_pkg::*;
#(
   parameter int unsigned N_NEURONS = 4,
   parameter int unsigned SHIFT     = 7
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          clr,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [MAC_W-1:0]              mac_result,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [ACT_W-1:0]              out_data,
   output logic [idx_w(N_NEURONS)-1:0]  out_index,
   output logic                          layer_done,
   output logic                          overflow
);

   localparam int unsigned IW = idx_w(N_NEURONS);
   localparam int unsigned DW = IW + ACT_W;
   localparam logic [IW-1:0] LAST = IW'(N_NEURONS - 1);
   localparam logic [MAC_W:0] ONE_W = 1;
   // Half an LSB of the rescaled result; zero when SHIFT is 0.
   localparam logic [MAC_W:0] RND = (ONE_W << SHIFT) >> 1;

   logic [IW-1:0]    idx_q, idx_d;
   logic             ovf_q, ovf_d;
   logic             done_q, done_d;
   logic             neg;
   logic [MAC_W:0]   sum;
   logic [MAC_W:0]   r;
   logic             sat;
   logic [ACT_W-1:0] act;
   logic             accept;
   logic             pop;
   logic [DW-1:0]    rdata;

   assign neg = mac_result[MAC_W-1];
   assign sum = {1'b0, mac_result} + RND;
   assign r   = sum >> SHIFT;
   assign sat = !neg && (r > (MAC_W+1)'(ACT_MAX));

   always_comb begin
      act = r[ACT_W-1:0];
      if (neg) act = '0;
      else if (sat) act = ACT_MAX;
   end

   assign accept = in_valid && in_ready;
   assign pop    = out_valid && out_ready;

   always_comb begin
      idx_d  = idx_q;
      ovf_d  = ovf_q;
      done_d = 1'b0;
      if (clr) begin
         idx_d = '0;
         ovf_d = 1'b0;
      end else begin
         if (accept) begin
            idx_d = (idx_q == LAST) ? '0 : idx_q + 1'b1;
            if (sat) ovf_d = 1'b1;
         end
         done_d = pop && (out_index == LAST);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q  <= '0;
         ovf_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         idx_q  <= idx_d;
         ovf_q  <= ovf_d;
         done_q <= done_d;
      end
   end

   act_fifo #(
      .DW(DW)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .push     (accept),
      .pop      (pop),
      .wdata    ({idx_q, act}),
      .not_full (in_ready),
      .not_empty(out_valid),
      .rdata    (rdata)
   );

   assign out_data   = rdata[ACT_W-1:0];
   assign out_index  = rdata[DW-1:ACT_W];
   assign layer_done = done_q;
   assign overflow   = ovf_q;

endmodule

// File: doc/activation_stage.md
ACTIVATION_STAGE -- requirements
Module: activation_stage

Interface
REQ-001 SHALL have parameter N_NEURONS, default 4: neurons per layer; output index wraps after this many results.
REQ-002 SHALL have parameter SHIFT, default 7: right-shift (fixed-point rescale) applied after ReLU; legal range 0..12.
REQ-003 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port clr, input, 1: synchronous flush of buffer, index counter and overflow flag.
REQ-006 SHALL have port in_valid, input, 1: MAC result valid (the neuron controller's ready pulse).
REQ-007 SHALL have port in_ready, output, 1: stage can accept a result this cycle.
REQ-008 SHALL have port mac_result, input, 21: signed two's-complement MAC accumulator output.
REQ-009 SHALL have port out_valid, output, 1: out_data/out_index valid.
REQ-010 SHALL have port out_ready, input, 1: downstream layer accepts the output.
REQ-011 SHALL have port out_data, output, 8: unsigned activation value.
REQ-012 SHALL have port out_index, output, clog2(N_NEURONS) (min 1): neuron index of out_data.
REQ-013 SHALL have port layer_done, output, 1: one-cycle pulse when the last neuron of a layer is delivered.
REQ-014 SHALL have port overflow, output, 1: sticky flag, set on any saturation.

Function
REQ-015 Accept SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-016 Activation SHALL be: negative mac_result -> 0; otherwise r = (x + 2^(SHIFT-1)) >> SHIFT (no rounding term when SHIFT=0), computed in 22 bits without wrap.
REQ-017 If r > 255, stored value SHALL be 255 and overflow SHALL set in the cycle after accept; overflow clears only by clr or reset.
REQ-018 Activated value and current index SHALL be written into a 2-entry FIFO on accept; out_valid SHALL assert the cycle after the first accept into an empty FIFO (latency 1).
REQ-019 Occupancy state machine SHALL have states EMPTY, ONE, FULL: accept-only moves up, pop-only moves down, accept+pop in ONE stays ONE.
REQ-020 in_ready SHALL equal (state != FULL) and SHALL NOT depend combinationally on out_ready; no accept in FULL even if a pop occurs that cycle.
REQ-021 out_valid SHALL equal (state != EMPTY); out_data/out_index SHALL hold stable while out_valid && !out_ready.
REQ-022 Index counter SHALL increment on each accept and wrap from N_NEURONS-1 to 0.
REQ-023 layer_done SHALL pulse high for one cycle, the cycle after a pop whose out_index = N_NEURONS-1.
REQ-024 FIFO order SHALL be strictly first-in first-out; no entry dropped or duplicated.
REQ-025 clr SHALL take priority over accept and pop in the same cycle: next state EMPTY, index 0, overflow 0, layer_done 0.

Reset
REQ-026 While rst_n=0, state SHALL be EMPTY, out_valid=0, in_ready=1 (after first clock edge post-release is not required; combinational from state), out_data=0, out_index=0, layer_done=0, overflow=0, index counter=0.
REQ-027 Reset assertion mid-operation SHALL discard buffered entries immediately, without waiting for clk.

Structure
REQ-028 Shared package SHALL hold MAC_W=21, ACT_W=8, ACT_MAX=255 and the occupancy state enumeration.
REQ-029 The 2-entry buffer SHALL be a sub-module act_fifo (data+index width parameterised); activation arithmetic and index counter stay in activation_stage.

Verification
REQ-030 SHIFT=7, mac_result=-5 accepted, out_ready=1 -> out_data=0, overflow=0.
REQ-031 SHIFT=7, mac_result=1000 -> out_data=8 one cycle after accept; mac_result=63 -> 0; 64 -> 1.
REQ-032 SHIFT=7, mac_result=40000 -> out_data=255, overflow=1 and remains 1 after further in-range results until clr.
REQ-033 out_ready=0, in_valid=1 with values 10,20,30 (pre-shift 1280,2560,3840) -> two accepted, in_ready=0, third held; raise out_ready -> outputs 10,20 then 30 in order.
REQ-034 N_NEURONS=4, four accepts, out_ready=1 -> out_index 0,1,2,3; layer_done pulses once after index-3 pop; fifth accept gets index 0.
REQ-035 FIFO FULL, pull rst_n low between edges -> out_valid=0 and in_ready=1 immediately; after release, first accept gets index 0; clr with simultaneous in_valid -> nothing stored.
